// File: rtl/ldpc_result_packer.sv
// Reads the decoded soft words after `over` rises and streams their sign bits out as LSB-first bytes.
// 10 cycles per byte (8 reads, capture, present); outputs hold while byte_ready is low and no reads are issued.
module ldpc_result_packer #(
  parameter int CODE_LEN = 24,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              over,
  output logic [ADDR_W-1:0] resmem_addr,
  input  logic [DATA_W-1:0] resmem_dout,
  output logic [7:0]        byte_data,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              byte_last,
  output logic              busy,
  output logic              done
);

  localparam int NBYTES = CODE_LEN / 8;
  localparam int BIDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAP,
    OUT,
    DONE
  } state_t;

  state_t            state;
  logic              over_q;
  logic [2:0]        wcnt;
  logic [BIDX_W-1:0] bidx;
  logic [6:0]        shreg;
  logic              start;
  logic              sign;
  logic              unused_ok;

  assign start     = over & ~over_q;
  assign sign      = resmem_dout[DATA_W-1];
  assign unused_ok = &{1'b0, resmem_dout};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      over_q      <= 1'b1;
      wcnt        <= '0;
      bidx        <= '0;
      shreg       <= '0;
      resmem_addr <= '0;
      byte_data   <= '0;
      byte_valid  <= 1'b0;
      byte_last   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      over_q <= over;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= READ;
            resmem_addr <= '0;
            wcnt        <= '0;
            bidx        <= '0;
            busy        <= 1'b1;
          end
        end
        READ: begin
          // Data returned this cycle belongs to the address issued last cycle.
          if (wcnt != 3'd0) shreg[wcnt - 3'd1] <= sign;
          wcnt <= wcnt + 3'd1;
          if (wcnt == 3'd7) state <= CAP;
          else resmem_addr <= resmem_addr + 1'b1;
        end
        CAP: begin
          byte_data  <= {sign, shreg};
          byte_valid <= 1'b1;
          byte_last  <= (bidx == BIDX_W'(NBYTES - 1));
          state      <= OUT;
        end
        OUT: begin
          if (byte_ready) begin
            byte_valid <= 1'b0;
            byte_last  <= 1'b0;
            if (byte_last) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              // Address is parked at bidx*8+7, so one step lands on the next byte's base.
              bidx        <= bidx + 1'b1;
              resmem_addr <= resmem_addr + 1'b1;
              state       <= READ;
            end
          end
        end
        DONE: begin
          busy        <= 1'b0;
          resmem_addr <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ldpc_result_packer.md
Name: ldpc_result_packer

Overview:
- Downstream stage of the min-sum LDPC decoder top.
- After the decoder's control block raises `over`, this block reads every decoded soft word from the result memory and takes its sign bit as the hard decision.
- It packs the hard decisions LSB-first into bytes and streams them out over a valid/ready handshake, with a last-byte flag and a completion pulse.
- It owns the result-memory address bus while busy.

Parameters:
- CODE_LEN, 24, number of result-memory words per frame; must be a nonzero multiple of 8.
- DATA_W, 8, result-memory word width; the hard bit is bit DATA_W-1.
- ADDR_W, 8, result-memory address width; CODE_LEN <= 2**ADDR_W.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- over  in  1  decoder-finished level from the decoder control block.
- resmem_addr  out  ADDR_W  result-memory read address, registered.
- resmem_dout  in  DATA_W  result-memory read data; 1-cycle synchronous read latency.
- byte_data  out  8  packed hard decisions.
- byte_valid  out  1  byte_data valid.
- byte_ready  in  1  downstream accepts.
- byte_last  out  1  qualifies the final byte of the frame; valid only with byte_valid.
- busy  out  1  high from the start edge until the done cycle inclusive.
- done  out  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset values:
  - resmem_addr=0, byte_data=0, byte_valid=0, byte_last=0, busy=0, done=0.
  - over_q=1, so an `over` already high at reset does not trigger a start.
- Start detect: start = over & ~over_q, with over_q registered every cycle. A start while not IDLE is ignored.
- States:
  - IDLE: on start, go to READ with resmem_addr=0, word counter wcnt=0 (0..7), byte index bidx=0, busy=1.
  - READ, 8 cycles:
    - each cycle resmem_addr presents address bidx*8+wcnt; wcnt increments.
    - resmem_dout[DATA_W-1] returned in the following cycle is shifted into byte position wcnt of the previous cycle.
    - After wcnt=7, go to CAP.
  - CAP, 1 cycle: capture the eighth word's sign into bit 7, load byte_data, go to OUT.
  - OUT:
    - byte_valid=1; byte_last=1 if bidx==CODE_LEN/8-1.
    - byte_data, byte_valid and byte_last are held stable until byte_valid&byte_ready.
    - On handshake: byte_valid=0 and byte_last=0 next cycle.
    - If not last, bidx++ and go to READ; resmem_addr continues at bidx*8.
    - If last, go to DONE.
  - DONE, 1 cycle: done=1, busy=1; next cycle IDLE with busy=0 and resmem_addr=0.
- Bit mapping: byte_data[j] of byte k = sign bit of word 8k+j; sign 1 is a negative LLR, decoded bit 1.
- Latency, with start seen in cycle E:
  - addresses 0..7 appear in E+1..E+8; CAP at E+9; byte_valid first high at E+10.
  - With byte_ready held 1, each subsequent byte takes 10 cycles (READ 8 + CAP 1 + OUT 1).
  - done occurs in the cycle after the final handshake.
- byte_ready while byte_valid=0 has no effect. byte_ready may be held low indefinitely; no data is lost or reordered.
- `over` falling mid-frame has no effect. A new rising edge of `over` during busy is ignored, not queued.
- rst mid-frame: next cycle all outputs take their reset values, the state is IDLE, and the partial frame is discarded.
- Counters never wrap past CODE_LEN-1. resmem_addr never exceeds CODE_LEN-1.

Test Plan:
1. Basic frame:
   - Stimulus: rst 2 cycles; memory words 0..23 = 0x80,0x7F alternating; byte_ready=1; over rises at cycle E.
   - Required: bytes 0x55,0x55,0x55 at E+10, E+20, E+30; byte_last only on the third; done at E+31; busy high E+1..E+31.
2. Backpressure:
   - Stimulus: words 0..7 = 0xFF, rest 0x00; byte_ready low 5 cycles while byte_valid is high.
   - Required: byte_data=0xFF held stable for 5 cycles, accepted on ready; then 0x00, 0x00; no addresses are issued while in OUT.
3. Bit order:
   - Stimulus: only word 3 = 0x81, word 13 = 0x90, others 0x01.
   - Required: bytes 0x08, 0x20, 0x00.
4. Retrigger ignored:
   - Stimulus: toggle over 0→1 twice mid-frame.
   - Required: exactly 3 bytes and one done pulse; a new frame starts only on an over edge after IDLE.
5. Reset mid-frame:
   - Stimulus: assert rst during the second READ.
   - Required: next cycle byte_valid=0, busy=0, resmem_addr=0; a subsequent over edge produces a full correct frame.
6. Over high at reset:
   - Stimulus: over=1 throughout reset release.
   - Required: no start; a start occurs only after over goes 0 then 1.
